// File: rtl/uart_tx_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_param: UART transmitter with input FIFO, runtime prescaler,        |
// | optional parity and one/two stop bits. UART_TX_MSB_FIRST_EN = MSB first.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module uart_tx_param #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   output logic                  Ready,
   input  logic                  Parity_Enable,
   input  logic                  Parity_Type,
   input  logic                  Two_Stop,
   input  logic [PRESCALE_W-1:0] Prescale,
   output logic                  S_Data,
   output logic                  Busy
);

   localparam int c_AW    = $clog2(FIFO_DEPTH);
   localparam int c_BIT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [c_AW:0]        c_FULL     = (c_AW + 1)'(FIFO_DEPTH);
   localparam logic [c_BIT_W-1:0]   c_LAST_BIT = c_BIT_W'(DATA_WIDTH - 1);
   localparam logic [PRESCALE_W-1:0] c_ONE     = PRESCALE_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   state_t                 r_state;
   logic [DATA_WIDTH-1:0]  r_mem [FIFO_DEPTH];
   logic [c_AW-1:0]        r_wr_ptr;
   logic [c_AW-1:0]        r_rd_ptr;
   logic [c_AW:0]          r_count;
   logic [c_AW:0]          w_count_next;
   logic                   r_ready;
   logic [DATA_WIDTH-1:0]  r_shift;
   logic [DATA_WIDTH-1:0]  w_shift_next;
   logic [DATA_WIDTH-1:0]  w_head;
   logic                   w_data_bit;
   logic [c_BIT_W-1:0]     r_bit_cnt;
   logic [PRESCALE_W-1:0]  r_baud_cnt;
   logic [PRESCALE_W-1:0]  r_prescale;
   logic [PRESCALE_W-1:0]  w_prescale_eff;
   logic                   r_par_en;
   logic                   r_par_bit;
   logic                   r_two_stop;
   logic                   r_s_data;
   logic                   r_busy;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_bit_end;
   logic                   w_stop_done;
   logic                   w_nonempty;

   assign w_nonempty     = (r_count != '0);
   assign w_push         = Data_Valid & r_ready;
   assign w_bit_end      = (r_baud_cnt == c_ONE);
   assign w_stop_done    = (r_state == ST_STOP) && w_bit_end && !(r_two_stop && (r_bit_cnt == '0));
   assign w_pop          = w_nonempty && ((r_state == ST_IDLE) || w_stop_done);
   assign w_head         = r_mem[r_rd_ptr];
   assign w_prescale_eff = (Prescale == '0) ? c_ONE : Prescale;

`ifdef UART_TX_MSB_FIRST_EN
   assign w_data_bit   = r_shift[DATA_WIDTH-1];
   assign w_shift_next = {r_shift[DATA_WIDTH-2:0], 1'b0};
`else
   assign w_data_bit   = r_shift[0];
   assign w_shift_next = {1'b0, r_shift[DATA_WIDTH-1:1]};
`endif

   always_comb begin
      w_count_next = r_count;
      if (w_push && !w_pop) begin
         w_count_next = r_count + 1'b1;
      end else if (w_pop && !w_push) begin
         w_count_next = r_count - 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= P_DATA;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ready  <= 1'b1;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count <= w_count_next;
         r_ready <= (w_count_next != c_FULL);
      end
   end

   // Line and Busy are registered from the current state, so they trail the state by one clock.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state    <= ST_IDLE;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_baud_cnt <= '0;
         r_prescale <= c_ONE;
         r_par_en   <= 1'b0;
         r_par_bit  <= 1'b0;
         r_two_stop <= 1'b0;
         r_s_data   <= 1'b1;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            ST_START:  r_s_data <= 1'b0;
            ST_DATA:   r_s_data <= w_data_bit;
            ST_PARITY: r_s_data <= r_par_bit;
            default:   r_s_data <= 1'b1;
         endcase
         r_busy <= (r_state != ST_IDLE);

         if (w_pop) begin
            r_shift    <= w_head;
            r_par_en   <= Parity_Enable;
            r_par_bit  <= (^w_head) ^ Parity_Type;
            r_two_stop <= Two_Stop;
            r_prescale <= w_prescale_eff;
            r_baud_cnt <= w_prescale_eff;
            r_bit_cnt  <= '0;
            r_state    <= ST_START;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_state <= ST_IDLE;
               end
               ST_START: begin
                  if (w_bit_end) begin
                     r_baud_cnt <= r_prescale;
                     r_bit_cnt  <= '0;
                     r_state    <= ST_DATA;
                  end else begin
                     r_baud_cnt <= r_baud_cnt - 1'b1;
                  end
               end
               ST_DATA: begin
                  if (w_bit_end) begin
                     r_baud_cnt <= r_prescale;
                     r_shift    <= w_shift_next;
                     if (r_bit_cnt == c_LAST_BIT) begin
                        r_bit_cnt <= '0;
                        r_state   <= r_par_en ? ST_PARITY : ST_STOP;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                     end
                  end else begin
                     r_baud_cnt <= r_baud_cnt - 1'b1;
                  end
               end
               ST_PARITY: begin
                  if (w_bit_end) begin
                     r_baud_cnt <= r_prescale;
                     r_bit_cnt  <= '0;
                     r_state    <= ST_STOP;
                  end else begin
                     r_baud_cnt <= r_baud_cnt - 1'b1;
                  end
               end
               ST_STOP: begin
                  if (w_bit_end) begin
                     if (r_two_stop && (r_bit_cnt == '0)) begin
                        r_bit_cnt  <= r_bit_cnt + 1'b1;
                        r_baud_cnt <= r_prescale;
                     end else begin
                        r_state <= ST_IDLE;
                     end
                  end else begin
                     r_baud_cnt <= r_baud_cnt - 1'b1;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign S_Data = r_s_data;
   assign Busy   = r_busy;
   assign Ready  = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// Bench for uart_tx_param: directed vector table, hand sequences and random frames
// compared against a per-clock line model built from the frame format.
module tb_uart_tx_param;
   localparam int DW = 8;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic [DW-1:0] P_DATA = '0;
   logic          Data_Valid = 1'b0;
   logic          Parity_Enable = 1'b0;
   logic          Parity_Type = 1'b0;
   logic          Two_Stop = 1'b0;
   logic [15:0]   Prescale = 16'd1;
   logic          Ready;
   logic          S_Data;
   logic          Busy;

   int total = 0;
   int bad   = 0;
   bit exp_q[$];
   logic [DW-1:0] burst_w[6];
   logic          rdy_seen[6];

   typedef struct {
      logic [DW-1:0] data;
      bit            pe;
      bit            pt;
      bit            ts;
      int            presc;
      int            exp_len;
   } vec_t;
   vec_t vecs[5];

   uart_tx_param #(.DATA_WIDTH(DW), .PRESCALE_W(16), .FIFO_DEPTH(4)) dut (
      .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid), .Ready(Ready),
      .Parity_Enable(Parity_Enable), .Parity_Type(Parity_Type), .Two_Stop(Two_Stop),
      .Prescale(Prescale), .S_Data(S_Data), .Busy(Busy)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", name, got, want);
      end
   endtask

   // Line model: each frame bit held for max(presc,1) clocks.
   function automatic void add_frame(logic [DW-1:0] d, bit pe, bit pt, bit ts, int presc);
      int p = (presc == 0) ? 1 : presc;
      bit bits[$];
      bits.push_back(1'b0);
      for (int i = 0; i < DW; i++) begin
`ifdef UART_TX_MSB_FIRST_EN
         bits.push_back(d[DW-1-i]);
`else
         bits.push_back(d[i]);
`endif
      end
      if (pe) bits.push_back((($countones(d) % 2) == 1) ^ pt);
      bits.push_back(1'b1);
      if (ts) bits.push_back(1'b1);
      foreach (bits[k]) repeat (p) exp_q.push_back(bits[k]);
   endfunction

   task automatic set_cfg(input bit pe, input bit pt, input bit ts, input int presc);
      Parity_Enable = pe;
      Parity_Type   = pt;
      Two_Stop      = ts;
      Prescale      = 16'(presc);
   endtask

   // Called just after a negedge; one word per rising edge.
   task automatic push_burst(input int n);
      for (int i = 0; i < n; i++) begin
         rdy_seen[i] = Ready;
         P_DATA      = burst_w[i];
         Data_Valid  = 1'b1;
         @(posedge CLK);
         @(negedge CLK);
      end
      Data_Valid = 1'b0;
   endtask

   // First sample is taken at the current negedge.
   task automatic check_stream(input string name, input int exp_busy, input bit scramble);
      int n = exp_q.size();
      int first_bad = -1;
      int busy_cnt = 0;
      logic got_d = 1'b0;
      logic got_b = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i > 0) @(negedge CLK);
         if (((S_Data !== exp_q[i]) || (Busy !== 1'b1)) && first_bad < 0) begin
            first_bad = i;
            got_d = S_Data;
            got_b = Busy;
         end
         if (Busy === 1'b1) busy_cnt++;
         if (scramble) begin
            Parity_Enable = 1'($urandom);
            Parity_Type   = 1'($urandom);
            Two_Stop      = 1'($urandom);
            Prescale      = 16'($urandom_range(0, 7));
         end
      end
      for (int k = 0; k < 64; k++) begin
         @(negedge CLK);
         if (Busy !== 1'b1) break;
         busy_cnt++;
      end
      total++;
      if (first_bad >= 0) begin
         bad++;
         $display("FAIL %s stream: clk %0d got line=%b busy=%b want line=%b busy=1",
                  name, first_bad, got_d, got_b, exp_q[first_bad]);
      end
      chk({name, " busy_len"}, 64'(busy_cnt), 64'(exp_busy));
      chk({name, " idle_after"}, {S_Data, Busy}, 2'b10);
      exp_q.delete();
   endtask

   task automatic run_frames(input int n, input int exp_busy, input bit scramble, input string name);
      push_burst(n);
      if (n == 1) @(negedge CLK);
      if (n <= 2) begin
         chk({name, " pre_start"}, {S_Data, Busy}, 2'b10);
         @(negedge CLK);
      end
      check_stream(name, exp_busy, scramble);
   endtask

   initial begin
      int bad_cycles;
      vecs[0] = '{data: 8'hA5, pe: 1, pt: 0, ts: 0, presc: 4, exp_len: 44};
      vecs[1] = '{data: 8'h00, pe: 1, pt: 1, ts: 1, presc: 1, exp_len: 12};
      vecs[2] = '{data: 8'h81, pe: 0, pt: 0, ts: 0, presc: 0, exp_len: 10};
      vecs[3] = '{data: 8'h1F, pe: 1, pt: 1, ts: 0, presc: 3, exp_len: 33};
      vecs[4] = '{data: 8'hFF, pe: 1, pt: 0, ts: 1, presc: 2, exp_len: 24};

      repeat (2) @(negedge CLK);
      chk("reset S_Data", S_Data, 1'b1);
      chk("reset Busy", Busy, 1'b0);
      chk("reset Ready", Ready, 1'b1);
      RST = 1'b1;
      @(negedge CLK);

      for (int i = 0; i < 5; i++) begin
         set_cfg(vecs[i].pe, vecs[i].pt, vecs[i].ts, vecs[i].presc);
         burst_w[0] = vecs[i].data;
         add_frame(vecs[i].data, vecs[i].pe, vecs[i].pt, vecs[i].ts, vecs[i].presc);
         run_frames(1, vecs[i].exp_len, 1'b0, $sformatf("vec%0d", i));
      end

      set_cfg(0, 0, 0, 2);
      burst_w[0] = 8'h55;
      burst_w[1] = 8'h0F;
      add_frame(8'h55, 0, 0, 0, 2);
      add_frame(8'h0F, 0, 0, 0, 2);
      run_frames(2, 40, 1'b0, "b2b");

      set_cfg(0, 0, 0, 8);
      for (int i = 0; i < 6; i++) burst_w[i] = 8'(8'h11 * (i + 1));
      for (int i = 0; i < 5; i++) add_frame(burst_w[i], 0, 0, 0, 8);
      fork
         push_burst(6);
         begin
            @(posedge CLK);
            repeat (3) @(negedge CLK);
            check_stream("fifo_full", 400, 1'b0);
         end
      join
      for (int i = 0; i < 6; i++) chk($sformatf("fifo Ready push%0d", i), rdy_seen[i], (i < 5) ? 1'b1 : 1'b0);

      for (int r = 0; r < 20; r++) begin
         int n = $urandom_range(1, 3);
         bit pe = 1'($urandom);
         bit pt = 1'($urandom);
         bit ts = 1'($urandom);
         int pr = $urandom_range(0, 5);
         int pe_eff = (pr == 0) ? 1 : pr;
         set_cfg(pe, pt, ts, pr);
         for (int i = 0; i < n; i++) begin
            burst_w[i] = 8'($urandom);
            add_frame(burst_w[i], pe, pt, ts, pr);
         end
         run_frames(n, n * pe_eff * (2 + DW + int'(pe) + int'(ts)), (n == 1), $sformatf("rnd%0d", r));
      end

      set_cfg(0, 0, 0, 4);
      burst_w[0] = 8'hC3;
      burst_w[1] = 8'h3C;
      burst_w[2] = 8'h99;
      push_burst(3);
      repeat (12) @(negedge CLK);
      chk("mid-frame Busy", Busy, 1'b1);
      #2 RST = 1'b0;
      #1;
      chk("async reset S_Data", S_Data, 1'b1);
      chk("async reset Busy", Busy, 1'b0);
      chk("async reset Ready", Ready, 1'b1);
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      bad_cycles = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge CLK);
         if (S_Data !== 1'b1 || Busy !== 1'b0) bad_cycles++;
      end
      chk("post-reset idle cycles", 64'(bad_cycles), 64'd0);
      chk("post-reset Ready", Ready, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter; successor to the fixed 8-bit serializer/FSM/parity/mux transmit path.
Adds configurable data width, a runtime baud prescaler, selectable one or two stop bits, and a small input FIFO with a valid/ready handshake, so bytes can be queued back-to-back.
Sits between the host-side data producer and the serial line pin.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9 supported).
PRESCALE_W, 16, width of the Prescale input.
FIFO_DEPTH, 4, input FIFO entries (power of two, >= 2).

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-low reset
P_DATA  in  DATA_WIDTH  parallel word to send
Data_Valid  in  1  producer has a word on P_DATA
Ready  out  1  FIFO can accept a word (not full)
Parity_Enable  in  1  insert parity bit
Parity_Type  in  1  0 = even, 1 = odd
Two_Stop  in  1  0 = one stop bit, 1 = two stop bits
Prescale  in  PRESCALE_W  clocks per bit; 0 is treated as 1
S_Data  out  1  serial line, idle high, registered
Busy  out  1  frame in progress

Behaviour:
- Interface: one clock, CLK; reset RST is asynchronous, active-low.
- Reset (RST=0, asynchronous):
  - S_Data=1, Busy=0, Ready=1.
  - FIFO emptied, FSM to IDLE, bit and baud counters cleared.
- Write handshake:
  - A word is accepted on a rising edge with Data_Valid=1 and Ready=1.
  - Ready = !full, registered from FIFO occupancy.
  - Data_Valid while Ready=0 is ignored; the word is not stored and there is no error.
- FIFO:
  - Simultaneous push and pop when full is impossible, because push requires Ready.
  - Simultaneous push and pop when non-empty keeps the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: S_Data=1. If the FIFO is non-empty:
    - pop the head into the shift register;
    - latch Parity_Enable, Parity_Type, Two_Stop and Prescale (config frozen for the whole frame);
    - go to START.
  - START: S_Data=0 for one bit period, then DATA.
  - DATA: DATA_WIDTH bit periods, LSB first. After the last bit go to PARITY if parity is enabled, else STOP.
  - PARITY: S_Data = XOR of the frame data, XOR Parity_Type. Lasts one bit period.
  - STOP: S_Data=1 for one bit period, or two if Two_Stop. At the end:
    - if the FIFO is non-empty, pop and go directly to START (no idle cycle between frames);
    - otherwise go to IDLE.
- Bit period:
  - Down-counter loaded with max(Prescale,1) at every bit start.
  - The bit advances when the counter reaches 1.
- Latency: a word written into an empty FIFO at edge E while IDLE:
  - FIFO occupancy visible at E, FSM leaves IDLE at E+1;
  - S_Data=0 and Busy=1 from edge E+2.
- Busy:
  - 1 in START/DATA/PARITY/STOP, 0 in IDLE.
  - Stays 1 across back-to-back frames.
- Frame length in clocks = max(Prescale,1) × (1 + DATA_WIDTH + Parity_Enable + 1 + Two_Stop).
- Input changes mid-frame: changes to the config inputs or Prescale have no effect until the next frame.
- Reset mid-frame: the line returns to 1 immediately and asynchronously; queued words are lost.

Optional Feature:
- Macro UART_TX_MSB_FIRST_EN.
- Defined: DATA bits are shifted MSB first.
- Undefined (default): DATA bits are shifted LSB first.
- Parity value and all timing are identical in both builds.

Test Plan:
- Single frame, DATA_WIDTH=8, Prescale=4, 0xA5, even parity, one stop:
  - S_Data per 4-clock bit = 0,1,0,1,0,0,1,0,1,0,1;
  - Busy high for exactly 44 clocks.
- Odd parity with 0x00, Two_Stop=1, Prescale=1:
  - bits = 0, eight 0s, parity 1, 1, 1;
  - Busy high for 12 clocks.
- Back-to-back 0x55 then 0x0F written on consecutive cycles, Prescale=2, no parity:
  - second start bit immediately follows the first stop bit;
  - Busy never drops between frames.
- FIFO full, FIFO_DEPTH=4, Prescale=8: push 6 words on consecutive cycles.
  - The first is popped into the shifter and 4 are queued.
  - Ready=0 at the sixth push; the sixth word is dropped.
  - Exactly 5 frames are transmitted.
- Prescale=0 with 0x81, no parity: every bit lasts 1 clock; frame = 10 clocks.
- Reset mid-DATA (RST low for 3 clocks) with 2 words queued:
  - S_Data=1, Busy=0, Ready=1 immediately;
  - no further frames after release.
